// File: rtl/dma_periph_pkg.sv
// Shared types and default sizing for the DMA peripheral endpoint.
// Sub-blocks import this package.
package dma_periph_pkg;

    localparam int DEFAULT_DW    = 8;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        REQ,
        XFER,
        RELEASE
    } dmaState_t;

endpackage

// File: rtl/dma_periph_fifo.sv
// Synchronous FIFO with one push and one pop per cycle.
// Pushing into a full FIFO is allowed only when a pop happens in the same cycle.
module dma_periph_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] pushData,
    input  logic          pop,
    output logic [DW-1:0] popData,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          doPush;
    logic          doPop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign doPop   = pop && !empty;
    assign doPush  = push && (!full || doPop);
    assign popData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            count <= count + {{AW{1'b0}}, doPush} - {{AW{1'b0}}, doPop};
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are valid, so clearing the array would only cost area.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/dma_periph_endpoint.sv
// 8237-style single-byte-handshake DMA peripheral endpoint: a DREQ/DACK
// controller bridging the system bus strobes to a local FIFO.
module dma_periph_endpoint
    import dma_periph_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic          CLK,
    input  logic          RESET,
    output logic          DREQ,
    input  logic          DACK_N,
    input  logic          IOR_N,
    input  logic          IOW_N,
    input  logic          EOP_N_IN,
    output logic          EOP_DRV,
    input  logic [DW-1:0] DB_IN,
    output logic [DW-1:0] DB_OUT,
    output logic          DB_OE,
    input  logic          start,
    input  logic          dir,
    input  logic [15:0]   length,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic [15:0]   remaining
);

    localparam int AW = $clog2(DEPTH);

    dmaState_t     state;
    logic          dirQ;
    logic          abortQ;
    logic          strobeQ;
    logic          strobeRaw;
    logic          complete;
    logic          extAbort;
    logic          fifoReady;
    logic          busPush;
    logic          busPop;
    logic          fifoPush;
    logic          fifoPop;
    logic [DW-1:0] fifoPushData;
    logic [DW-1:0] fifoHead;
    logic          fifoFull;
    logic          fifoEmpty;
    logic [AW:0]   fifoCount;

    // A strobe only counts while DACK_N is low, so DACK_N masks it before registering.
    assign strobeRaw = dirQ ? IOW_N : IOR_N;
    assign complete  = (state == XFER) && !strobeQ && strobeRaw && !DACK_N;
    // Our own EOP_DRV pulls the shared line low; that must not read back as an abort.
    assign extAbort  = (state != IDLE) && !EOP_N_IN && !EOP_DRV;
    assign fifoReady = dirQ ? (fifoCount != (AW+1)'(DEPTH)) : (fifoCount != '0);

    assign busPush = complete && dirQ;
    assign busPop  = complete && !dirQ;

    // The bus side owns the FIFO port on a completion cycle; the local side is
    // expected to push only for periph->mem and pop only for mem->periph.
    assign fifoPush     = busPush || (wr_valid && !fifoFull);
    assign fifoPushData = busPush ? DB_IN : wr_data;
    assign fifoPop      = busPop || (rd_ready && !fifoEmpty);

    assign wr_ready = !fifoFull;
    assign rd_valid = !fifoEmpty;
    assign rd_data  = fifoHead;

    assign DB_OE  = ((state == REQ) || (state == XFER)) && !dirQ && !IOR_N && !DACK_N;
    assign DB_OUT = DB_OE ? fifoHead : '0;

    dma_periph_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .reset    (RESET),
        .push     (fifoPush),
        .pushData (fifoPushData),
        .pop      (fifoPop),
        .popData  (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            dirQ      <= 1'b0;
            abortQ    <= 1'b0;
            strobeQ   <= 1'b1;
            remaining <= '0;
            DREQ      <= 1'b0;
            EOP_DRV   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            strobeQ <= strobeRaw | DACK_N;
            done    <= 1'b0;
            EOP_DRV <= complete && (remaining == 16'd1);
            if (complete && (remaining != '0)) remaining <= remaining - 16'd1;

            case (state)
                IDLE: begin
                    if (start && (length != '0)) begin
                        state     <= ARMED;
                        dirQ      <= dir;
                        remaining <= length;
                        abortQ    <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ARMED: begin
                    if (extAbort) begin
                        state  <= RELEASE;
                        abortQ <= 1'b1;
                    end else if (fifoReady) begin
                        state <= REQ;
                        DREQ  <= 1'b1;
                    end
                end
                REQ: begin
                    if (extAbort) begin
                        state  <= RELEASE;
                        abortQ <= 1'b1;
                        DREQ   <= 1'b0;
                    end else if (!DACK_N) begin
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (complete || extAbort) begin
                        state  <= RELEASE;
                        DREQ   <= 1'b0;
                        abortQ <= abortQ || extAbort;
                    end
                end
                RELEASE: begin
                    if (DACK_N) begin
                        if (abortQ || extAbort || (remaining == '0)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ARMED;
                        end
                    end else if (extAbort) begin
                        abortQ <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_periph_endpoint.sv
// Directed bench for dma_periph_endpoint: a byte scoreboard checks bus and
// local data, with handshake, terminal-count, abort and reset checks in between.
module tb_dma_periph_endpoint;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          DREQ;
    logic          DACK_N;
    logic          IOR_N;
    logic          IOW_N;
    logic          EOP_N_IN;
    logic          EOP_DRV;
    logic [DW-1:0] DB_IN;
    logic [DW-1:0] DB_OUT;
    logic          DB_OE;
    logic          start;
    logic          dir;
    logic [15:0]   length;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [15:0]   remaining;

    int            nChecks = 0;
    int            nFails  = 0;
    int            eopSeen = 0;
    int            eopBase;
    logic [DW-1:0] expQ[$];
    logic [15:0]   expRem;

    dma_periph_endpoint #(.DW(DW), .DEPTH(8)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .DREQ      (DREQ),
        .DACK_N    (DACK_N),
        .IOR_N     (IOR_N),
        .IOW_N     (IOW_N),
        .EOP_N_IN  (EOP_N_IN),
        .EOP_DRV   (EOP_DRV),
        .DB_IN     (DB_IN),
        .DB_OUT    (DB_OUT),
        .DB_OE     (DB_OE),
        .start     (start),
        .dir       (dir),
        .length    (length),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (EOP_DRV) eopSeen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic waitDreq();
        for (int i = 0; i < 40 && !DREQ; i++) tick(1);
        check("dreq_wait", DREQ, 1);
    endtask

    task automatic pushLocal(input logic [DW-1:0] d);
        check("wr_ready", wr_ready, 1);
        wr_valid = 1'b1;
        wr_data  = d;
        tick(1);
        wr_valid = 1'b0;
        expQ.push_back(d);
    endtask

    task automatic popLocal();
        logic [DW-1:0] exp;
        check("rd_valid", rd_valid, 1);
        if (expQ.size() == 0) begin
            check("sb_nonempty_pop", expQ.size(), 1);
        end else begin
            exp = expQ.pop_front();
            check("rd_data", rd_data, exp);
        end
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
    endtask

    task automatic startXfer(input logic d, input logic [15:0] len);
        start  = 1'b1;
        dir    = d;
        length = len;
        tick(1);
        start  = 1'b0;
        expRem = len;
        check("start_busy", busy, 1);
        check("start_remaining", remaining, len);
    endtask

    // One periph->mem byte: DACK, then an IOR pulse, then DACK release.
    task automatic busRead(input logic expEop);
        logic [DW-1:0] exp;
        waitDreq();
        DACK_N = 1'b0;
        tick(1);
        check("rd_oe_before_ior", DB_OE, 0);
        IOR_N = 1'b0;
        #1;
        check("rd_oe_during_ior", DB_OE, 1);
        if (expQ.size() == 0) begin
            check("sb_nonempty_bus", expQ.size(), 1);
        end else begin
            exp = expQ.pop_front();
            check("db_out", DB_OUT, exp);
        end
        tick(1);
        IOR_N = 1'b1;
        #1;
        check("rd_oe_after_ior", DB_OE, 0);
        tick(1);
        expRem = expRem - 16'd1;
        check("rd_dreq_release", DREQ, 0);
        check("rd_eop_drv", EOP_DRV, expEop);
        check("rd_remaining", remaining, expRem);
        DACK_N = 1'b1;
        tick(1);
        check("rd_eop_one_cycle", EOP_DRV, 0);
    endtask

    // One mem->periph byte, with DACK_N held low for holdDack extra cycles afterwards.
    task automatic busWrite(input logic [DW-1:0] d, input logic expEop, input int holdDack);
        waitDreq();
        DACK_N = 1'b0;
        tick(1);
        IOW_N = 1'b0;
        DB_IN = d;
        tick(1);
        IOW_N = 1'b1;
        tick(1);
        DB_IN = '0;
        expQ.push_back(d);
        expRem = expRem - 16'd1;
        check("wr_dreq_release", DREQ, 0);
        check("wr_eop_drv", EOP_DRV, expEop);
        check("wr_remaining", remaining, expRem);
        for (int i = 0; i < holdDack; i++) begin
            tick(1);
            check("wr_dreq_held_low", DREQ, 0);
        end
        DACK_N = 1'b1;
        tick(1);
    endtask

    task automatic checkDone();
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        tick(1);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        RESET    = 1'b1;
        DACK_N   = 1'b1;
        IOR_N    = 1'b1;
        IOW_N    = 1'b1;
        EOP_N_IN = 1'b1;
        DB_IN    = '0;
        start    = 1'b0;
        dir      = 1'b0;
        length   = '0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        expRem   = '0;
        tick(2);
        check("rst_dreq", DREQ, 0);
        check("rst_eop", EOP_DRV, 0);
        check("rst_db_oe", DB_OE, 0);
        check("rst_db_out", DB_OUT, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_remaining", remaining, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_ready", wr_ready, 1);
        RESET = 1'b0;
        tick(1);

        // periph->mem, three bytes, terminal count on the third.
        eopBase = eopSeen;
        pushLocal(8'h11);
        pushLocal(8'h22);
        pushLocal(8'h33);
        startXfer(1'b0, 16'd3);
        busRead(1'b0);
        busRead(1'b0);
        busRead(1'b1);
        check("t1_remaining", remaining, 0);
        check("t1_eop_count", eopSeen - eopBase, 1);
        checkDone();

        // mem->periph, two bytes, DREQ held off until DACK_N returns high.
        startXfer(1'b1, 16'd2);
        busWrite(8'hA5, 1'b0, 2);
        busWrite(8'h5A, 1'b1, 0);
        checkDone();
        popLocal();
        popLocal();
        check("t2_fifo_empty", rd_valid, 0);

        // mem->periph with a full FIFO: no request until the local side pops.
        for (int i = 0; i < 8; i++) pushLocal(8'h80 + 8'(i));
        check("t3_full", wr_ready, 0);
        startXfer(1'b1, 16'd10);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("t3_dreq_blocked", DREQ, 0);
        end
        popLocal();
        waitDreq();
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        expQ.delete();
        check("t3_rst_busy", busy, 0);
        check("t3_rst_empty", rd_valid, 0);

        // External EOP abort after two of five bytes.
        eopBase = eopSeen;
        for (int i = 0; i < 5; i++) pushLocal(8'h41 + 8'(i));
        startXfer(1'b0, 16'd5);
        busRead(1'b0);
        busRead(1'b0);
        waitDreq();
        EOP_N_IN = 1'b0;
        tick(1);
        EOP_N_IN = 1'b1;
        check("t4_abort_dreq", DREQ, 0);
        tick(1);
        check("t4_abort_remaining", remaining, 3);
        check("t4_no_eop_drv", eopSeen - eopBase, 0);
        checkDone();
        popLocal();
        popLocal();
        popLocal();
        check("t4_drained", rd_valid, 0);

        // Reset in the middle of a read strobe.
        pushLocal(8'h77);
        pushLocal(8'h78);
        startXfer(1'b0, 16'd2);
        waitDreq();
        DACK_N = 1'b0;
        tick(1);
        IOR_N = 1'b0;
        #1;
        check("t5_oe_active", DB_OE, 1);
        RESET = 1'b1;
        tick(1);
        check("t5_rst_dreq", DREQ, 0);
        check("t5_rst_oe", DB_OE, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_empty", rd_valid, 0);
        check("t5_rst_remaining", remaining, 0);
        RESET  = 1'b0;
        IOR_N  = 1'b1;
        DACK_N = 1'b1;
        expQ.delete();
        tick(3);
        check("t5_stays_idle", busy, 0);
        check("t5_no_dreq", DREQ, 0);

        // Ignored strobes, zero-length start and start while busy.
        pushLocal(8'h99);
        start  = 1'b1;
        dir    = 1'b0;
        length = 16'd0;
        tick(1);
        start  = 1'b0;
        check("t6_zero_len_busy", busy, 0);
        startXfer(1'b0, 16'd1);
        waitDreq();
        for (int i = 0; i < 2; i++) begin
            IOR_N = 1'b0;
            tick(2);
            check("t6_oe_no_dack", DB_OE, 0);
            IOR_N = 1'b1;
            tick(2);
        end
        check("t6_remaining_held", remaining, 1);
        check("t6_no_pop", rd_valid, 1);
        start  = 1'b1;
        length = 16'd5;
        tick(1);
        start  = 1'b0;
        check("t6_busy_start_ignored", remaining, 1);
        busRead(1'b1);
        checkDone();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
